// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the bus/counter widths.
package dmem_responder_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte-enabled write and registered read.
// Contents are never reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the pipeline memory stage.
// Stalls each request LATENCY cycles, then completes in a single DONE cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] i_p_addr,
  input  logic              i_p_read,
  input  logic              i_p_write,
  input  logic [WORD_W-1:0] i_p_writedata,
  input  logic [BE_W-1:0]   i_p_byteenable,
  output logic [WORD_W-1:0] o_p_readdata,
  output logic              o_p_waitrequest
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic              wr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              req, accept, is_wr;
  logic [AW-1:0]     mem_addr;
  logic              mem_re, mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr;

  assign req    = i_p_read | i_p_write;
  assign accept = (state_q == StIdle) & req;
  assign unused_addr = ^{i_p_addr[WORD_W-1:AW+2], i_p_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= i_p_addr[AW+1:2];
        wr_q    <= i_p_write;
        wdata_q <= i_p_writedata;
        be_q    <= i_p_byteenable;
      end
    end
  end

  // In IDLE the live request drives the RAM so LATENCY==1 reads land on the accepting edge.
  assign is_wr    = (state_q == StIdle) ? i_p_write : wr_q;
  assign mem_addr = (state_q == StIdle) ? i_p_addr[AW+1:2] : addr_q;
  assign mem_re   = (state_d == StDone) & ~is_wr;
  assign mem_we   = (state_q == StDone) & wr_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .be_i   (be_q),
    .wdata_i(wdata_q),
    .re_i   (mem_re),
    .rdata_o(mem_rdata)
  );

  assign o_p_readdata    = (state_q == StDone && !wr_q) ? mem_rdata : '0;
  assign o_p_waitrequest = req & (state_q != StDone);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand-written reset/protocol sequences,
// and randomized traffic against a word-array memory model (LATENCY 3 and 1).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] p_addr  [2];
  logic        p_read  [2];
  logic        p_write [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_be    [2];
  logic [31:0] rdata   [2];
  logic        wreq    [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [2][1024];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          mut;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.LATENCY(3), .DEPTH_WORDS(1024)) dut0 (
    .clk(clk), .rst(rst), .i_p_addr(p_addr[0]), .i_p_read(p_read[0]),
    .i_p_write(p_write[0]), .i_p_writedata(p_wdata[0]), .i_p_byteenable(p_be[0]),
    .o_p_readdata(rdata[0]), .o_p_waitrequest(wreq[0])
  );

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst), .i_p_addr(p_addr[1]), .i_p_read(p_read[1]),
    .i_p_write(p_write[1]), .i_p_writedata(p_wdata[1]), .i_p_byteenable(p_be[1]),
    .o_p_readdata(rdata[1]), .o_p_waitrequest(wreq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 after the completion edge.
  task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input bit mut,
                     input bit gap, input logic [31:0] exp, input string name);
    int n;
    int lat;
    lat = (d == 0) ? 3 : 1;
    p_read[d] = rd; p_write[d] = wr; p_addr[d] = a; p_wdata[d] = wd; p_be[d] = be;
    n = 0;
    @(negedge clk);
    while (wreq[d] && n < 20) begin
      n++;
      @(posedge clk); #1;
      if (mut && n == 1) begin
        p_addr[d] = a ^ 32'h4; p_wdata[d] = ~wd; p_be[d] = 4'hF;
      end
      @(negedge clk);
    end
    check($sformatf("%s_lat", name), 32'(n), 32'(lat));
    check($sformatf("%s_rdata", name), rdata[d], wr ? 32'h0 : exp);
    @(posedge clk); #1;
    if (gap) begin
      p_read[d] = 1'b0; p_write[d] = 1'b0;
      @(negedge clk);
      check($sformatf("%s_idle_rdata", name), rdata[d], 32'h0);
      check($sformatf("%s_idle_wreq", name), 32'(wreq[d]), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      p_addr[d] = '0; p_read[d] = 0; p_write[d] = 0; p_wdata[d] = '0; p_be[d] = '0;
    end
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_state", 32'(dut0.state_q), 32'(StIdle));
    check("rst_wreq_noreq", 32'(wreq[0]), 32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    p_read[0] = 1'b1; #1;
    check("rst_wreq_req", 32'(wreq[0]), 32'h1);
    p_read[0] = 1'b0; #1;
    check("rst_rdata_lat1", rdata[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Vector table on the LATENCY=3 instance
    vecs.push_back('{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 32'h10,   32'h000000AA, 4'h1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEAA});
    vecs.push_back('{1'b1, 1'b0, 32'h13,   32'h0,        4'h0, 1'b0, 32'hDEADBEAA});
    vecs.push_back('{1'b0, 1'b1, 32'h1004, 32'h00000055, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h4,    32'h0,        4'h0, 1'b0, 32'h00000055});
    vecs.push_back('{1'b0, 1'b1, 32'hC,    32'h11111111, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h8,    32'h00000077, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8,    32'h0,        4'h0, 1'b0, 32'h00000077});
    vecs.push_back('{1'b0, 1'b1, 32'h8,    32'h00000099, 4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8,    32'h0,        4'h0, 1'b0, 32'h00000099});
    vecs.push_back('{1'b1, 1'b0, 32'hC,    32'h0,        4'h0, 1'b1, 32'h11111111});
    for (int i = 0; i < vecs.size(); i++) begin
      txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].mut,
          (i % 2) == 1, vecs[i].exp, $sformatf("vec%0d", i));
    end
    p_read[0] = 1'b0; p_write[0] = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: preload word 0 then read it back
    txn(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0, "lat1_pre");
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, "lat1_rd");

    // Request dropped mid-BUSY still commits the write
    p_write[0] = 1'b1; p_addr[0] = 32'h28; p_wdata[0] = 32'h5A5A5A5A; p_be[0] = 4'hF;
    @(posedge clk); #1;
    p_write[0] = 1'b0;
    @(negedge clk);
    check("drop_wreq", 32'(wreq[0]), 32'h0);
    repeat (4) @(posedge clk); #1;
    txn(0, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5A5A5A5A, "drop_rd");

    // Reset during BUSY discards the write
    txn(0, 1'b0, 1'b1, 32'h20, 32'h1234ABCD, 4'hF, 1'b0, 1'b1, 32'h0, "rb_pre");
    p_write[0] = 1'b1; p_addr[0] = 32'h20; p_wdata[0] = 32'h0000CAFE; p_be[0] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("rb_state", 32'(dut0.state_q), 32'(StIdle));
    check("rb_rdata", rdata[0], 32'h0);
    p_write[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234ABCD, "rb_rd");

    // Reset during DONE discards the write
    txn(0, 1'b0, 1'b1, 32'h24, 32'h0BADF00D, 4'hF, 1'b0, 1'b1, 32'h0, "rd_pre");
    p_write[0] = 1'b1; p_addr[0] = 32'h24; p_wdata[0] = 32'h0000CAFE; p_be[0] = 4'hF;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    p_write[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    // Read reaching DONE, then reset zeroes readdata at once
    p_read[0] = 1'b1; p_addr[0] = 32'h24;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rd_done_rdata", rdata[0], 32'h0BADF00D);
    rst = 1'b0; #1;
    check("rd_rst_rdata", rdata[0], 32'h0);
    p_read[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BADF00D, "rd_rd");

    // Randomized traffic on a small word pool, with address aliasing
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        int unsigned idx;
        logic [31:0] wd;
        idx = 64 + 5 * k;
        wd = $urandom;
        mdl[d][idx] = wd;
        txn(d, 1'b0, 1'b1, 32'(idx) << 2, wd, 4'hF, 1'b0, 1'b1, 32'h0, "rnd_pre");
      end
      for (int i = 0; i < 40; i++) begin
        int unsigned idx;
        int unsigned op;
        logic [31:0] a, wd, exp;
        logic [3:0]  be;
        idx = 64 + 5 * $urandom_range(0, 7);
        a = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        op = $urandom_range(0, 2);
        wd = $urandom;
        be = 4'($urandom);
        exp = mdl[d][idx];
        if (op != 0) begin
          for (int b = 0; b < 4; b++) if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
        txn(d, op != 1, op != 0, a, wd, be, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, exp, $sformatf("rnd%0d_%0d", d, i));
      end
      p_read[d] = 1'b0; p_write[d] = 1'b0;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 3, number of o_p_waitrequest-high cycles per transaction, legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port i_p_addr, input, 32, byte address from pipeline memory stage.
REQ-006 Port i_p_read, input, 1, read request, held by initiator until accepted.
REQ-007 Port i_p_write, input, 1, write request, held by initiator until accepted.
REQ-008 Port i_p_writedata, input, 32, store data.
REQ-009 Port i_p_byteenable, input, 4, per-byte write mask; bit n enables writedata[8n+7:8n].
REQ-010 Port o_p_readdata, output, 32, load data, valid only in completion cycle.
REQ-011 Port o_p_waitrequest, output, 1, stall to pipeline; high = request not yet completed.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 The block SHALL use word index i_p_addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored; upper bits ignored (modulo wrap).
REQ-014 In IDLE with read or write asserted, the block SHALL latch addr, op, writedata, byteenable; next state DONE if LATENCY==1, else BUSY with 4-bit counter = LATENCY-2.
REQ-015 In BUSY the block SHALL go to DONE when counter==0, else decrement counter.
REQ-016 DONE SHALL last exactly one cycle, then IDLE.
REQ-017 o_p_waitrequest SHALL equal (i_p_read|i_p_write) & (state!=DONE), combinationally; low when no request.
REQ-018 Request first seen in cycle c0 SHALL see waitrequest high c0..c0+LATENCY-1 and low at c0+LATENCY (completion cycle).
REQ-019 Reads: the array word SHALL be registered on the edge entering DONE; o_p_readdata SHALL present it during DONE and be 0 in all other states.
REQ-020 Writes: enabled bytes SHALL be committed on the edge leaving DONE; disabled bytes unchanged.
REQ-021 Read and write both asserted SHALL be treated as a write; o_p_readdata 0 for that transaction.
REQ-022 Latched request values SHALL be used; input changes during BUSY do not alter the transaction.
REQ-023 Request deasserted during BUSY (protocol violation) SHALL still complete internally (write committed) and return to IDLE.
REQ-024 Back-to-back requests: a request present in the cycle after DONE SHALL be accepted in IDLE as new; minimum spacing LATENCY+1 cycles.
REQ-025 Read-after-write to the same word SHALL return the newly written data.

Reset
REQ-026 On rst low: state IDLE, counter 0, latched request cleared, o_p_readdata 0, o_p_waitrequest follows REQ-017 from IDLE.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset during BUSY or DONE SHALL abort; pending write discarded.

Structure
REQ-029 Shared package SHALL hold state enum (IDLE/BUSY/DONE), WORD_W=32, BE_W=4, LAT_MAX=15.
REQ-030 One sub-module dmem_array: single-port synchronous RAM, byte-enabled write, registered read, DEPTH_WORDS parameter.

Verification
REQ-031 LATENCY=3, write 0xDEADBEEF, be=0xF, addr 0x10 -> waitrequest high 3 cycles, low 4th; subsequent read addr 0x10 returns 0xDEADBEEF in its completion cycle.
REQ-032 Word 0x10=0xDEADBEEF; write 0x000000AA be=0x1 -> read returns 0xDEADBEAA; addr 0x13 reads same word.
REQ-033 LATENCY=1, read with no prior write of addr 0x0 after preload 0x12345678 -> waitrequest high 1 cycle, readdata 0x12345678 next cycle, 0 afterwards.
REQ-034 DEPTH_WORDS=1024, write addr 0x1004 data 0x55 -> read addr 0x4 returns 0x55 (wrap).
REQ-035 rst low during BUSY of write 0xCAFE to addr 0x20 -> state IDLE, readdata 0, later read of 0x20 returns prior value.
REQ-036 read+write asserted together, writedata 0x77 addr 0x8 -> readdata 0 at completion, subsequent read returns 0x77; addr changed mid-BUSY has no effect.
